// File: rtl/select_encode_regfile.sv
// select_encode_regfile
// Destination side of the datapath bus. Holds general registers R0..R15,
// latches the bus into the register picked by the IR Ra/Rb/Rc fields,
// produces the one-hot R0out..R15out strobes for the bus source encoder,
// the sign-extended constant C, and the base-address view of R0.
// There is no valid/ready handshake here: Rin/Rout/BAout are single-cycle
// strobes from the control unit, and they take effect in the cycle they are high.
module select_encode_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        bus_in,
  input  logic [31:0]              IR,
  input  logic                     Gra,
  input  logic                     Grb,
  input  logic                     Grc,
  input  logic                     Rin,
  input  logic                     Rout,
  input  logic                     BAout,
  output logic [NREG-1:0]          r_out,
  output logic [NREG*DATA_W-1:0]   r_data,
  output logic [DATA_W-1:0]        r0_bus,
  output logic [31:0]              c_sign,
  output logic                     sel_err
);

  // IR field positions for the three register specifiers
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;
  logic [3:0]        sel;
  logic [NREG-1:0]   dec;
  logic [DATA_W-1:0] regs [NREG];

  logic              any_access;
  logic              multi_g;
  logic              no_g;
  logic              illegal;

  // IR[31:27] carries the opcode, which this block never looks at
  logic              unused_opcode;
  assign unused_opcode = &{1'b0, IR[31:27]};

  assign ra = IR[RA_LSB +: 4];
  assign rb = IR[RB_LSB +: 4];
  assign rc = IR[RC_LSB +: 4];

  // Field select: OR-merge of the gated fields; with no G* asserted this is R0
  always_comb begin
    sel = (ra & {4{Gra}}) | (rb & {4{Grb}}) | (rc & {4{Grc}});
  end

  // One-hot decode of the selected register number
  always_comb begin
    dec = {{(NREG-1){1'b0}}, 1'b1} << sel;
  end

  // Read strobes go to the bus encoder in the same cycle, no latency
  always_comb begin
    r_out = (Rout | BAout) ? dec : {NREG{1'b0}};
  end

  // Illegal control combinations: ambiguous register select while accessing,
  // two read sources at once, or a write with no register field selected
  always_comb begin
    any_access = Rin | Rout | BAout;
    multi_g    = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
    no_g       = ~(Gra | Grb | Grc);
    illegal    = (multi_g & any_access) | (Rout & BAout) | (Rin & no_g);
  end

  // Register file write; clear wipes everything and overrides a same-edge write
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (Rin) begin
      regs[sel] <= bus_in;
    end
  end

  // Sticky illegal-select flag; only clear can drop it
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sel_err <= 1'b0;
    end else if (illegal) begin
      sel_err <= 1'b1;
    end
  end

  // Flatten the register array for the bus mux
  always_comb begin
    r_data = '0;
    for (int i = 0; i < NREG; i++) begin
      r_data[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  // Base-address mode reads R0 as zero without touching the stored value
  always_comb begin
    r0_bus = BAout ? {DATA_W{1'b0}} : regs[0];
  end

  // Sign-extend the 19-bit immediate held in IR[18:0]
  always_comb begin
    c_sign = {{13{IR[18]}}, IR[18:0]};
  end

endmodule

// File: tb/tb_select_encode_regfile.sv
// Testbench for select_encode_regfile: directed cases followed by random
// control/data traffic compared with a behavioural register-file model.
module tb_select_encode_regfile;

  localparam int DATA_W = 32;
  localparam int NREG   = 16;

  logic                   clock;
  logic                   clear;
  logic [DATA_W-1:0]      bus_in;
  logic [31:0]            IR;
  logic                   Gra, Grb, Grc;
  logic                   Rin, Rout, BAout;
  logic [NREG-1:0]        r_out;
  logic [NREG*DATA_W-1:0] r_data;
  logic [DATA_W-1:0]      r0_bus;
  logic [31:0]            c_sign;
  logic                   sel_err;

  // behavioural model state
  logic [DATA_W-1:0] m_reg [NREG];
  logic              m_err;

  int n_checks = 0;
  int n_pass   = 0;

  select_encode_regfile #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clock  (clock),
    .clear  (clear),
    .bus_in (bus_in),
    .IR     (IR),
    .Gra    (Gra),
    .Grb    (Grb),
    .Grc    (Grc),
    .Rin    (Rin),
    .Rout   (Rout),
    .BAout  (BAout),
    .r_out  (r_out),
    .r_data (r_data),
    .r0_bus (r0_bus),
    .c_sign (c_sign),
    .sel_err(sel_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  // register number the instruction names, per the OR-merge rule
  function automatic int m_sel();
    int s = 0;
    if (Gra) s = s | int'(IR[26:23]);
    if (Grb) s = s | int'(IR[22:19]);
    if (Grc) s = s | int'(IR[18:15]);
    return s;
  endfunction

  function automatic logic [31:0] m_rout();
    if (Rout || BAout) return 32'(2 ** m_sel());
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_csign();
    logic [31:0] v;
    v = {13'b0, IR[18:0]};
    if (IR[18]) v = v - 32'h0008_0000;
    return v;
  endfunction

  function automatic logic m_illegal();
    int ng;
    ng = int'(Gra) + int'(Grb) + int'(Grc);
    if (ng > 1 && (Rin || Rout || BAout)) return 1'b1;
    if (Rout && BAout) return 1'b1;
    if (Rin && ng == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ir, input logic ga, input logic gb, input logic gc,
                       input logic rin, input logic rout, input logic ba, input logic [31:0] bus);
    IR = ir; Gra = ga; Grb = gb; Grc = gc;
    Rin = rin; Rout = rout; BAout = ba; bus_in = bus;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] ir_fields(input int ra, input int rb, input int rc);
    logic [31:0] v;
    v = 32'h0;
    v[26:23] = 4'(ra);
    v[22:19] = 4'(rb);
    v[18:15] = 4'(rc);
    return v;
  endfunction

  // combinational outputs, checked mid-cycle with current inputs
  task automatic check_comb(input string tag);
    #1;
    check({tag, ".r_out"},  32'(r_out), m_rout());
    check({tag, ".r0_bus"}, r0_bus, BAout ? 32'h0 : m_reg[0]);
    check({tag, ".c_sign"}, c_sign, m_csign());
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s.R%0d", tag, i), r_data[i*DATA_W +: DATA_W], m_reg[i]);
    check({tag, ".sel_err"}, 32'(sel_err), 32'(m_err));
  endtask

  // one clock edge with the inputs now applied; model follows the edge
  task automatic step();
    int s;
    logic wr, il;
    logic [31:0] d;
    s  = m_sel();
    wr = Rin && !clear;
    il = m_illegal() && !clear;
    d  = bus_in;
    @(posedge clock);
    #1;
    if (wr) m_reg[s] = d;
    if (il) m_err = 1'b1;
  endtask

  // ---------------- sequence ----------------
  initial begin
    idle();
    clear = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_state("reset");
    clear = 1'b0;

    // reset mid-cycle with R5 previously loaded
    drive(ir_fields(5, 0, 0), 1, 0, 0, 1, 0, 0, 32'h1234);
    step();
    check_state("r5_load");
    idle();
    #2;
    clear = 1'b1;
    model_reset();
    #1;
    check_state("async_clr");
    drive(ir_fields(5, 0, 0), 1, 0, 0, 0, 1, 0, 32'h0);
    #1;
    check("async_clr.r_out", 32'(r_out), 32'h0020);
    check("async_clr.r0_bus", r0_bus, 32'h0);
    // write attempted while clear held must be dropped
    drive(ir_fields(5, 0, 0), 1, 0, 0, 1, 0, 0, 32'h55);
    step();
    check_state("clr_write");
    clear = 1'b0;
    // first edge after release accepts a write
    drive(ir_fields(9, 0, 0), 1, 0, 0, 1, 0, 0, 32'h0BAD_F00D);
    step();
    check("release.R9", r_data[9*DATA_W +: DATA_W], 32'h0BAD_F00D);

    // write / readback
    drive(ir_fields(3, 0, 0), 1, 0, 0, 1, 0, 0, 32'hDEAD_BEEF);
    step();
    check_state("wr3");
    drive(ir_fields(3, 0, 0), 1, 0, 0, 0, 1, 0, 32'h0);
    check_comb("rd3");
    check("rd3.direct", 32'(r_out), 32'h0008);

    // same-cycle read/write of R7
    drive(ir_fields(0, 7, 0), 0, 1, 0, 1, 0, 0, 32'h11);
    step();
    drive(ir_fields(0, 7, 0), 0, 1, 0, 1, 1, 0, 32'h22);
    #1;
    check("rw7.r_out", 32'(r_out), 32'h0080);
    check("rw7.before", r_data[7*DATA_W +: DATA_W], 32'h11);
    step();
    check("rw7.after", r_data[7*DATA_W +: DATA_W], 32'h22);

    // base-address zeroing of R0
    drive(ir_fields(0, 0, 0), 1, 0, 0, 1, 0, 0, 32'hCAFE_0000);
    step();
    drive(ir_fields(0, 0, 0), 1, 0, 0, 0, 0, 1, 32'h0);
    #1;
    check("ba.r0_bus", r0_bus, 32'h0);
    check("ba.r_out", 32'(r_out), 32'h0001);
    check("ba.R0kept", r_data[DATA_W-1:0], 32'hCAFE_0000);
    drive(ir_fields(0, 0, 0), 1, 0, 0, 0, 1, 0, 32'h0);
    #1;
    check("rout.r0_bus", r0_bus, 32'hCAFE_0000);
    // no G* asserted reads R0 strobe
    drive(ir_fields(6, 6, 6), 0, 0, 0, 0, 1, 0, 32'h0);
    #1;
    check("nog.r_out", 32'(r_out), 32'h0001);

    // constant sign extension
    drive(32'h0004_0000, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("csign.neg", c_sign, 32'hFFFC_0000);
    drive(32'h0000_007F, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("csign.pos", c_sign, 32'h0000_007F);

    // error flag: Ra=1 and Rb=2 merge to R3 and the write still happens
    drive(ir_fields(1, 2, 0), 1, 1, 0, 1, 0, 0, 32'h3333_AAAA);
    step();
    check("err.flag", 32'(sel_err), 32'h1);
    check("err.R3", r_data[3*DATA_W +: DATA_W], 32'h3333_AAAA);
    idle();
    repeat (3) step();
    check("err.sticky", 32'(sel_err), 32'h1);
    check_state("err");
    clear = 1'b1;
    model_reset();
    #1;
    check("err.cleared", 32'(sel_err), 32'h0);
    clear = 1'b0;

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      drive($urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
            $urandom());
      check_comb($sformatf("rnd%0d", it));
      step();
      check_state($sformatf("rnd%0d", it));
      if (it % 75 == 74) begin
        #2;
        clear = 1'b1;
        model_reset();
        #1;
        check_state($sformatf("rndclr%0d", it));
        clear = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/select_encode_regfile.md
Name: select_encode_regfile

Overview:
Destination side of the datapath bus: holds general registers R0..R15 and latches the bus value into the register selected by the instruction register (IR) fields. It decodes IR Ra/Rb/Rc fields into the one-hot R0out..R15out strobes consumed by the bus source encoder. It also produces the sign-extended constant (C) driven on the bus CSIGN input and applies base-address (BA) zeroing of R0. It sits between the control unit (Gra/Grb/Grc/Rin/Rout/BAout) and the bus.

Parameters:
DATA_W, 32, bus and register width
NREG, 16, number of general registers (fixed 16; 4-bit IR fields)

Ports:
clock  input  1  system clock, rising-edge active
clear  input  1  asynchronous active-high reset
bus_in  input  DATA_W  current bus value (output of bus mux)
IR  input  32  instruction register contents
Gra  input  1  select IR[26:23] (Ra)
Grb  input  1  select IR[22:19] (Rb)
Grc  input  1  select IR[18:15] (Rc)
Rin  input  1  load bus_in into selected register
Rout  input  1  drive selected register onto bus
BAout  input  1  drive selected register onto bus, with R0 reading as zero
r_out  output  NREG  one-hot R0out..R15out strobes to the bus encoder
r_data  output  NREG*DATA_W  flattened register contents; R_i at bits [i*DATA_W +: DATA_W]
r0_bus  output  DATA_W  value presented on bus input R0 (zeroed under BAout)
c_sign  output  32  sign-extended IR[18:0]
sel_err  output  1  sticky: illegal select combination seen

Behaviour:
- Field select is combinational: sel = (IR[26:23] & {4{Gra}}) | (IR[22:19] & {4{Grb}}) | (IR[18:15] & {4{Grc}}).
- Decode sel to one-hot dec[15:0].
- r_out = dec when (Rout | BAout), else 16'h0000. It is combinational, with no latency.
- Write: on rising clock with Rin=1, R[sel] <= bus_in. Other registers hold their values.
- A written value is visible on r_data and r0_bus the cycle after the edge.
- Reading and writing the same register in the same cycle: the bus sees the old value, and the new value is stored at the edge.
- r0_bus = (BAout) ? 0 : R0. The stored R0 is not affected by BAout. R0 is fully writable.
- c_sign = {{13{IR[18]}}, IR[18:0]}. It is combinational.
- sel_err is set on a rising clock when any of the following holds, and clears only on clear:
  - more than one of Gra/Grb/Grc is 1 while (Rin|Rout|BAout) is 1;
  - Rout and BAout are both 1;
  - Rin is 1 with none of Gra/Grb/Grc asserted.
- On an illegal-combination cycle the write still proceeds using the OR-merged sel. The flag only records the event.
- When no G* signal is asserted, sel=0. In that case r_out = 16'h0001 if Rout|BAout.
- Reset (clear=1, asynchronous):
  - all R0..R15 <= 0 and sel_err <= 0 immediately, regardless of clock;
  - a write in progress at the same edge is discarded;
  - r_out, r0_bus and c_sign remain combinational during reset, so r0_bus = 0.
- Reset release: the first write is accepted at the first rising edge with clear=0.
- X-free: every output is a defined function of registered state and the inputs.

Test Plan:
- Reset: assert clear mid-cycle with a prior R5=0x1234 -> R5 and every register read 0 immediately; sel_err=0; with Gra=1, Rout=1, IR[26:23]=5 -> r_out=16'h0020.
- Write/readback: IR[26:23]=3, Gra=1, Rin=1, bus_in=0xDEADBEEF for one edge -> next cycle r_data[3]=0xDEADBEEF, all others unchanged. Then Rout=1 -> r_out=16'h0008.
- Same-cycle read/write: R7=0x11, IR Rb=7, Grb=1, Rout=1, Rin=1, bus_in=0x22 -> r_out=16'h0080 during the cycle, r_data[7]=0x11 before the edge and 0x22 after.
- BA zeroing: R0=0xCAFE0000, Ra=0, Gra=1, BAout=1 -> r0_bus=0, r_out=16'h0001. With Rout=1 instead -> r0_bus=0xCAFE0000.
- Constant: IR[18:0]=19'h40000 -> c_sign=0xFFFC0000; IR[18:0]=19'h0007F -> c_sign=0x0000007F.
- Error flag: Gra=1, Grb=1, Rin=1, Ra=1, Rb=2 -> after the edge sel_err=1, R3 is written (sel=1|2=3), and sel_err stays 1 until clear.
